// File: rtl/stream_pkg.sv
// Shared defaults and the operand-pair payload type for the pair-splitting stream block.
package stream_pkg;

    localparam int unsigned WIDTH          = 8;
    localparam int unsigned AMOUNT_OF_DATA = 16;
    localparam int unsigned DEPTH          = 4;

    typedef struct packed {
        logic [WIDTH-1:0] op1;
        logic [WIDTH-1:0] op2;
    } operand_pair_t;

endpackage

// File: rtl/stream_chan_fifo.sv
// One output channel: a DEPTH-word FIFO with a packet word counter that marks
// the last word of every AMOUNT_OF_DATA-word packet.
module stream_chan_fifo #(
    parameter int unsigned WIDTH          = stream_pkg::WIDTH,
    parameter int unsigned AMOUNT_OF_DATA = stream_pkg::AMOUNT_OF_DATA,
    parameter int unsigned DEPTH          = stream_pkg::DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full_c,
    output logic [WIDTH-1:0] data_c,
    output logic             valid_c,
    input  logic             ready,
    output logic             last_c
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WORD_W = (AMOUNT_OF_DATA > 1) ? $clog2(AMOUNT_OF_DATA) : 1;
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(AMOUNT_OF_DATA - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [WORD_W-1:0] word_cnt;
    logic              pop;

    // Head word is shown straight from storage, so it is visible one edge after the push.
    assign valid_c = (count != '0);
    assign full_c  = (count == FULL_CNT);
    assign data_c  = mem[rd_ptr];
    assign last_c  = valid_c && (word_cnt == LAST_WORD);
    assign pop     = valid_c && ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            word_cnt <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + WORD_W'(1);
            end
            // Push and pop together leave occupancy unchanged.
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/stream_pair_split.sv
// Splits an operand-pair stream into two independently drained operand streams,
// each framed into AMOUNT_OF_DATA-word packets.
module stream_pair_split #(
    parameter int unsigned WIDTH          = stream_pkg::WIDTH,
    parameter int unsigned AMOUNT_OF_DATA = stream_pkg::AMOUNT_OF_DATA,
    parameter int unsigned DEPTH          = stream_pkg::DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*WIDTH-1:0] data_in,
    input  logic               valid_in,
    output logic               ready_in,
    output logic [WIDTH-1:0]   data_o1,
    output logic               valid_o1,
    input  logic               ready_1,
    output logic               last_o1,
    output logic [WIDTH-1:0]   data_o2,
    output logic               valid_o2,
    input  logic               ready_2,
    output logic               last_o2
);

    logic full1;
    logic full2;
    logic push;

    // Accept only when both channels have room so a pair is never split across time.
    assign ready_in = rst && !full1 && !full2;
    assign push     = valid_in && ready_in;

    stream_chan_fifo #(
        .WIDTH          (WIDTH),
        .AMOUNT_OF_DATA (AMOUNT_OF_DATA),
        .DEPTH          (DEPTH)
    ) u_chan1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (data_in[2*WIDTH-1:WIDTH]),
        .full_c    (full1),
        .data_c    (data_o1),
        .valid_c   (valid_o1),
        .ready     (ready_1),
        .last_c    (last_o1)
    );

    stream_chan_fifo #(
        .WIDTH          (WIDTH),
        .AMOUNT_OF_DATA (AMOUNT_OF_DATA),
        .DEPTH          (DEPTH)
    ) u_chan2 (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (data_in[WIDTH-1:0]),
        .full_c    (full2),
        .data_c    (data_o2),
        .valid_c   (valid_o2),
        .ready     (ready_2),
        .last_c    (last_o2)
    );

endmodule

// File: tb/tb_stream_pair_split.sv
// Self-checking bench for stream_pair_split: table-driven streaming plus a
// per-channel scoreboard fed at input acceptance and drained at output transfers.
module tb_stream_pair_split;
    import stream_pkg::*;

    localparam int unsigned W = WIDTH;
    localparam int unsigned N = AMOUNT_OF_DATA;
    localparam int unsigned D = DEPTH;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } exp_t;

    typedef struct {
        operand_pair_t pair;
        logic [W-1:0]  exp1;
        logic [W-1:0]  exp2;
        logic          exp_last;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [2*W-1:0] data_in = '0;
    logic           valid_in = 1'b0;
    logic           ready_in;
    logic [W-1:0]   data_o1;
    logic           valid_o1;
    logic           ready_1 = 1'b0;
    logic           last_o1;
    logic [W-1:0]   data_o2;
    logic           valid_o2;
    logic           ready_2 = 1'b0;
    logic           last_o2;

    int   checks = 0;
    int   errors = 0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t log1[$];
    exp_t log2[$];
    int   in_cnt = 0;
    int   out1_n = 0;
    int   out2_n = 0;
    logic hold1 = 1'b0, hold2 = 1'b0;
    exp_t hv1, hv2;

    stream_pair_split u_dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready_in (ready_in),
        .data_o1  (data_o1),
        .valid_o1 (valid_o1),
        .ready_1  (ready_1),
        .last_o1  (last_o1),
        .data_o2  (data_o2),
        .valid_o2 (valid_o2),
        .ready_2  (ready_2),
        .last_o2  (last_o2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, i.e. the transfer about to happen.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            q1.delete();
            q2.delete();
            in_cnt = 0;
            hold1  = 1'b0;
            hold2  = 1'b0;
        end else begin
            if (hold1) chk("hold1", {valid_o1, data_o1, last_o1}, {1'b1, hv1});
            if (hold2) chk("hold2", {valid_o2, data_o2, last_o2}, {1'b1, hv2});
            if (!valid_o1) chk("last1_idle", last_o1, 0);
            if (!valid_o2) chk("last2_idle", last_o2, 0);
            if (valid_o1 && ready_1) begin
                if (q1.size() == 0) chk("extra_word1", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("sb1", {data_o1, last_o1}, e);
                end
                log1.push_back({data_o1, last_o1});
                out1_n++;
            end
            if (valid_o2 && ready_2) begin
                if (q2.size() == 0) chk("extra_word2", 1, 0);
                else begin
                    e = q2.pop_front();
                    chk("sb2", {data_o2, last_o2}, e);
                end
                log2.push_back({data_o2, last_o2});
                out2_n++;
            end
            hold1 = valid_o1 && !ready_1;
            hv1   = {data_o1, last_o1};
            hold2 = valid_o2 && !ready_2;
            hv2   = {data_o2, last_o2};
            if (valid_in && ready_in) begin
                q1.push_back({data_in[2*W-1:W], (in_cnt % N) == N - 1});
                q2.push_back({data_in[W-1:0], (in_cnt % N) == N - 1});
                in_cnt++;
            end
        end
    end

    task automatic send(input logic [2*W-1:0] d);
        logic acc = 1'b0;
        data_in  = d;
        valid_in = 1'b1;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = ready_in;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        ready_1 = 1'b1;
        ready_2 = 1'b1;
        while ((q1.size() != 0 || q2.size() != 0) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_q1", q1.size(), 0);
        chk("drain_q2", q2.size(), 0);
    endtask

    initial begin
        vec_t tbl[64];
        int   base1, base2, b1, b2, acc_n, sent, cyc, lastpos, nlast;
        logic acc;

        for (int i = 0; i < 64; i++) begin
            tbl[i].pair.op1 = W'(i);
            tbl[i].pair.op2 = W'(255 - i);
            tbl[i].exp1     = W'(i);
            tbl[i].exp2     = W'(255 - i);
            tbl[i].exp_last = (i % 16) == 15;
        end

        // Reset: ten cycles with all outputs quiet.
        repeat (10) @(posedge clk);
        #1;
        chk("rst_ready_in", ready_in, 0);
        chk("rst_valid", {valid_o1, valid_o2}, 0);
        chk("rst_last", {last_o1, last_o2}, 0);
        chk("rst_data", {data_o1, data_o2}, 0);
        rst = 1'b1;
        #1;
        chk("post_rst_ready_in", ready_in, 1);

        // Streaming with both outputs always ready.
        ready_1 = 1'b1;
        ready_2 = 1'b1;
        base1 = log1.size();
        base2 = log2.size();
        for (int i = 0; i < 64; i++) send(tbl[i].pair);
        drain();
        chk("stream_len1", log1.size() - base1, 64);
        chk("stream_len2", log2.size() - base2, 64);
        for (int i = 0; i < 64; i++) begin
            if (base1 + i < log1.size())
                chk("tbl_o1", log1[base1 + i], {tbl[i].exp1, tbl[i].exp_last});
            if (base2 + i < log2.size())
                chk("tbl_o2", log2[base2 + i], {tbl[i].exp2, tbl[i].exp_last});
        end

        // Stream 1 stalled: only DEPTH pairs fit, stream 2 keeps draining.
        ready_1 = 1'b0;
        ready_2 = 1'b1;
        b1 = out1_n;
        b2 = out2_n;
        acc_n = 0;
        valid_in = 1'b1;
        data_in = 16'h1090;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            acc = ready_in;
            @(posedge clk);
            #1;
            if (acc) begin
                acc_n++;
                data_in = data_in + 16'h0101;
            end
        end
        valid_in = 1'b0;
        chk("stall_accepted", acc_n, D);
        chk("stall_ready_in", ready_in, 0);
        chk("stall_out2", out2_n - b2, 4);
        chk("stall_out1", out1_n - b1, 0);
        ready_1 = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("release_out1", out1_n - b1, 4);
        chk("release_ready_in", ready_in, 1);
        drain();

        // Random readies and random valid_in.
        b1 = out1_n;
        b2 = out2_n;
        sent = 0;
        cyc = 0;
        valid_in = 1'b0;
        while (sent < 128 && cyc < 5000) begin
            if (!valid_in && $urandom_range(0, 1) == 1) begin
                valid_in = 1'b1;
                data_in  = (2*W)'($urandom);
            end
            ready_1 = 1'($urandom_range(0, 1));
            ready_2 = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = valid_in && ready_in;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                sent++;
                valid_in = 1'b0;
            end
        end
        valid_in = 1'b0;
        chk("rand_sent", sent, 128);
        drain();
        chk("rand_out1", out1_n - b1, 128);
        chk("rand_out2", out2_n - b2, 128);

        // Steady state: two words per channel, one push and one pop per cycle.
        ready_1 = 1'b0;
        ready_2 = 1'b0;
        send(16'hA050);
        send(16'hA151);
        ready_1 = 1'b1;
        ready_2 = 1'b1;
        valid_in = 1'b1;
        data_in = 16'hB060;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("steady_occ1", u_dut.u_chan1.count, 2);
            chk("steady_occ2", u_dut.u_chan2.count, 2);
            chk("steady_ready_in", ready_in, 1);
            @(posedge clk);
            #1;
            data_in = data_in + 16'h0101;
        end
        valid_in = 1'b0;
        drain();

        // Reset in the middle of a packet with words still buffered.
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        ready_1 = 1'b1;
        ready_2 = 1'b1;
        for (int i = 0; i < 7; i++) send((2*W)'(16'hC000 + i));
        ready_1 = 1'b0;
        ready_2 = 1'b0;
        for (int i = 0; i < 3; i++) send((2*W)'(16'hD000 + i));
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_valid", {valid_o1, valid_o2}, 0);
        chk("midrst_ready_in", ready_in, 0);
        chk("midrst_last", {last_o1, last_o2}, 0);
        chk("midrst_data", {data_o1, data_o2}, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        ready_1 = 1'b1;
        ready_2 = 1'b1;
        base1 = log1.size();
        for (int i = 0; i < 16; i++) send((2*W)'(16'hE000 + i * 16'h0101));
        drain();
        chk("pkt_words", log1.size() - base1, 16);
        lastpos = -1;
        nlast = 0;
        for (int i = base1; i < log1.size(); i++) begin
            if (log1[i].l) begin
                nlast++;
                if (lastpos < 0) lastpos = i - base1;
            end
        end
        chk("pkt_last_pos", lastpos, 15);
        chk("pkt_last_cnt", nlast, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_pair_split.md
STREAM_PAIR_SPLIT -- requirements
Module: stream_pair_split

Interface
REQ-001 Parameter WIDTH, default 8: bits per operand word.
REQ-002 Parameter AMOUNT_OF_DATA, default 16: words per packet on each output stream.
REQ-003 Parameter DEPTH, default 4: per-channel buffer depth; power of two, at least 2.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-low.
REQ-006 data_in  input  2*WIDTH  operand pair; [2*WIDTH-1:WIDTH] is operand 1, [WIDTH-1:0] is operand 2.
REQ-007 valid_in  input  1  data_in is valid.
REQ-008 ready_in  output  1  block can accept data_in this cycle.
REQ-009 data_o1 / data_o2  output  WIDTH  operand stream 1 / operand stream 2.
REQ-010 valid_o1 / valid_o2  output  1  data_o1 / data_o2 is valid.
REQ-011 ready_1 / ready_2  input  1  downstream accepts stream 1 / stream 2.
REQ-012 last_o1 / last_o2  output  1  current word is the final word of a packet.

Function
REQ-013 An input transfer occurs when valid_in and ready_in are both 1 on a rising clk edge.
REQ-014 An output transfer on channel k occurs when valid_ok and ready_k are both 1 on a rising clk edge.
REQ-015 ready_in shall be 1 only when both channel buffers hold fewer than DEPTH words.
- On each input transfer, operand 1 is pushed to buffer 1 and operand 2 to buffer 2 in the same cycle.
REQ-016 ready_in shall be combinational from buffer occupancy only, never from valid_in.
REQ-017 Each channel drains independently; a stalled ready_1 shall not block channel 2 until buffer 1 is full.
REQ-018 Latency: a word accepted at edge N shall be presented on data_ok/valid_ok by edge N+1, if that channel's buffer was empty.
REQ-019 Once valid_ok is asserted, data_ok and last_ok shall hold stable until the transfer completes.
REQ-020 Each channel shall order its words first-in, first-out, with no loss and no duplication.
REQ-021 Simultaneous push and pop on a full channel: the push is not offered, because ready_in is 0.
REQ-022 Simultaneous push and pop on a non-full channel: occupancy is unchanged.
REQ-023 Simultaneous push and pop on an empty channel: the pop is not offered, because valid_ok is 0.
REQ-024 Each channel shall keep a word counter of width $clog2(AMOUNT_OF_DATA), incremented on each output transfer.
- The counter wraps from AMOUNT_OF_DATA-1 to 0.
REQ-025 last_ok shall equal valid_ok AND (word counter = AMOUNT_OF_DATA-1).
REQ-026 Pointers shall wrap modulo DEPTH.
- Full and empty shall be distinguished by an occupancy count of width $clog2(DEPTH)+1.

Reset
REQ-027 While rst=0, the following shall be 0, asynchronously: pointers, occupancy counts, word counters, valid_o1, valid_o2, last_o1, last_o2.
REQ-028 While rst=0, ready_in shall be 0.
REQ-029 data_o1 and data_o2 shall reset to 0.
REQ-030 Reset asserted mid-packet shall discard all buffered words and restart packet framing at word 0.
REQ-031 Reset deassertion needs no synchronizer inside the block; the first transfer is permitted at the first rising edge after deassertion.

Structure
REQ-032 Package stream_pkg shall hold the default constants WIDTH, AMOUNT_OF_DATA and DEPTH.
REQ-033 Package stream_pkg shall hold a packed struct typedef operand_pair_t with fields op1 and op2, each WIDTH bits.
REQ-034 The per-channel buffer with word counter and last generation shall be one sub-module, stream_chan_fifo, instantiated twice.

Verification
REQ-035 Ten cycles of reset, then 64 pairs {i, 255-i} with ready_1=ready_2=1.
- Required: data_o1 = 0..63 and data_o2 = 255..192, in order.
- Required: last_o1 and last_o2 high on words 15, 31, 47 and 63 only.
REQ-036 ready_1=0, ready_2=1, valid_in held high.
- Required: exactly DEPTH=4 pairs accepted, then ready_in=0.
- Required: stream 2 emits 4 words; stream 1 emits none.
- Then release ready_1: stream 1 emits the 4 words in order and ready_in returns to 1.
REQ-037 Random ready_1 and ready_2, each high with 50% probability; random valid_in; 128 pairs.
- Required: both output streams match the reference sequence word for word.
- Required: no lost or duplicated words.
- Required: data_ok stable while valid_ok=1 and ready_k=0.
REQ-038 Assert rst=0 after 7 words of a packet, with buffers non-empty.
- Required: same cycle, valid_o1=valid_o2=0 and ready_in=0.
- After release: the next packet's last_ok occurs on its 16th word.
REQ-039 Keep each channel at 2 words with one push and one pop every cycle for 20 cycles.
- Required: occupancy constant at 2.
- Required: ready_in stays 1.
- Required: output order preserved.
